mask_run_filter: RTL and testbench

- Upstream feeder for the centroid stage.
- Consumes the raw per-pixel stream (coordinates plus 8-bit channel value), thresholds each pixel against a frame-latched [lower, upper] window, and applies horizontal run-length erosion. A pixel is emitted only when the ERODE_LEN most recent pixels on the same line, up to and including the current one, all passed the threshold.
- Emits per-pixel x/y/valid strobes and a single end-of-frame tabulate pulse, ready to drive the centroid block's x_in/y_in/valid_in/tabulate_in directly.

---
 rtl/mask_run_filter_pkg.sv | 27 ++
 rtl/mask_run_filter_if.sv | 40 ++++
 rtl/mask_run_filter_threshold_stage.sv | 78 +++++++
 rtl/mask_run_filter.sv | 161 ++++++++++++++++
 tb/tb_mask_run_filter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mask_run_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vision_pkg
//  Description : Types and constants shared between the mask run filter and
//                the centroid block. Also holds the threshold window helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vision_pkg;

  typedef logic [10:0] hcount_t;   // pixel column
  typedef logic [9:0]  vcount_t;   // pixel row
  typedef logic [7:0]  pixel_t;    // single channel value
  typedef logic [20:0] count_t;    // per-frame masked pixel count
  typedef logic [3:0]  run_t;      // consecutive-pass run length

  localparam int H_ACTIVE_DEFAULT = 1280;
  localparam int V_ACTIVE_DEFAULT = 720;

  localparam count_t c_count_max = '1;

  // Inclusive window test; an inverted window (lo > up) passes nothing.
  function automatic logic in_window(pixel_t p, pixel_t lo, pixel_t up);
    return (p >= lo) && (p <= up);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mask_run_filter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mask_run_filter_if
//  Description : Pixel-stream bus of the mask run filter.
//                Source side : hcount_in, vcount_in, pixel_in, valid_in,
//                              lower_bound_in, upper_bound_in
//                Result side : x_out, y_out, valid_out, tabulate_out,
//                              pixel_count_out
//                master = the block feeding pixels and consuming results,
//                slave  = the filter itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mask_run_filter_if;
  import vision_pkg::*;

  hcount_t hcount_in;
  vcount_t vcount_in;
  pixel_t  pixel_in;
  logic    valid_in;
  pixel_t  lower_bound_in;
  pixel_t  upper_bound_in;

  hcount_t x_out;
  vcount_t y_out;
  logic    valid_out;
  logic    tabulate_out;
  count_t  pixel_count_out;

  modport master (
    output hcount_in, vcount_in, pixel_in, valid_in, lower_bound_in, upper_bound_in,
    input  x_out, y_out, valid_out, tabulate_out, pixel_count_out
  );

  modport slave (
    input  hcount_in, vcount_in, pixel_in, valid_in, lower_bound_in, upper_bound_in,
    output x_out, y_out, valid_out, tabulate_out, pixel_count_out
  );

endinterface
`default_nettype wire

// File: rtl/mask_run_filter_threshold_stage.sv
`default_nettype none
// ============================================================================
//  Module      : threshold_stage
//  Description : First pipeline stage. Latches the threshold window on the
//                first pixel of each frame and registers coordinates, valid
//                and the window-compare result.
//  Ports       : clk_in, rst_in           - clock, synchronous reset
//                hcount_in/vcount_in      - input coordinates
//                pixel_in, valid_in       - channel value and strobe
//                lower/upper_bound_in     - window candidates
//                hcount_out/vcount_out    - registered coordinates
//                valid_out, pass_out      - registered strobe and result
//  Revision    : 1.0 - initial release
// ============================================================================
module threshold_stage
  import vision_pkg::*;
(
  input  logic    clk_in,
  input  logic    rst_in,
  input  hcount_t hcount_in,
  input  vcount_t vcount_in,
  input  pixel_t  pixel_in,
  input  logic    valid_in,
  input  pixel_t  lower_bound_in,
  input  pixel_t  upper_bound_in,
  output hcount_t hcount_out,
  output vcount_t vcount_out,
  output logic    valid_out,
  output logic    pass_out
);

  hcount_t hcount_q, hcount_d;
  vcount_t vcount_q, vcount_d;
  logic    valid_q,  valid_d;
  logic    pass_q,   pass_d;
  pixel_t  lower_q,  lower_d;
  pixel_t  upper_q,  upper_d;

  always_comb begin
    lower_d  = lower_q;
    upper_d  = upper_q;
    // The frame-start pixel captures the window and is itself judged by it,
    // so the compare below uses the _d values rather than the held ones.
    if (valid_in && (hcount_in == '0) && (vcount_in == '0)) begin
      lower_d = lower_bound_in;
      upper_d = upper_bound_in;
    end
    hcount_d = hcount_in;
    vcount_d = vcount_in;
    valid_d  = valid_in;
    pass_d   = valid_in && in_window(pixel_in, lower_d, upper_d);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hcount_q <= '0;
      vcount_q <= '0;
      valid_q  <= 1'b0;
      pass_q   <= 1'b0;
      lower_q  <= '0;
      upper_q  <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      valid_q  <= valid_d;
      pass_q   <= pass_d;
      lower_q  <= lower_d;
      upper_q  <= upper_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign valid_out  = valid_q;
  assign pass_out   = pass_q;

endmodule
`default_nettype wire

// File: rtl/mask_run_filter.sv
`default_nettype none
// ============================================================================
//  Module      : mask_run_filter
//  Description : Thresholds a pixel stream against a frame-latched window and
//                applies horizontal run-length erosion. A pixel is emitted
//                (at its run centre) once ERODE_LEN consecutive pixels of a
//                line have passed. Counts emitted pixels per frame and pulses
//                tabulate_out one cycle after the frame's last pixel result.
//  Ports       : clk_in, rst_in - clock, synchronous active-high reset
//                bus (slave)    - pixel stream in, mask stream and frame
//                                 statistics out
//  Revision    : 1.0 - initial release
// ============================================================================
module mask_run_filter
  import vision_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE  = V_ACTIVE_DEFAULT,
  parameter int ERODE_LEN = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  mask_run_filter_if.slave bus
);

  localparam run_t    c_erode_len     = run_t'(ERODE_LEN);
  localparam hcount_t c_centre_offset = hcount_t'((ERODE_LEN - 1) / 2);
  localparam hcount_t c_last_h        = hcount_t'(H_ACTIVE - 1);
  localparam vcount_t c_last_v        = vcount_t'(V_ACTIVE - 1);

  // --------------------------------------------------------------------------
  // Stage 1: window compare and coordinate register
  // --------------------------------------------------------------------------
  hcount_t s1_hcount;
  vcount_t s1_vcount;
  logic    s1_valid;
  logic    s1_pass;

  threshold_stage u_threshold_stage (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .hcount_in      (bus.hcount_in),
    .vcount_in      (bus.vcount_in),
    .pixel_in       (bus.pixel_in),
    .valid_in       (bus.valid_in),
    .lower_bound_in (bus.lower_bound_in),
    .upper_bound_in (bus.upper_bound_in),
    .hcount_out     (s1_hcount),
    .vcount_out     (s1_vcount),
    .valid_out      (s1_valid),
    .pass_out       (s1_pass)
  );

  // --------------------------------------------------------------------------
  // Stage 2: run tracking, mask output and frame accounting
  // --------------------------------------------------------------------------
  run_t    run_q,       run_d;
  hcount_t prev_h_q,    prev_h_d;
  vcount_t prev_v_q,    prev_v_d;
  hcount_t x_q,         x_d;
  vcount_t y_q,         y_d;
  logic    valid_out_q, valid_out_d;
  logic    eof_q,       eof_d;
  logic    tabulate_q,  tabulate_d;
  count_t  frame_cnt_q, frame_cnt_d;
  count_t  pix_cnt_q,   pix_cnt_d;

  hcount_t w_prev_h_plus1;
  logic    w_line_break;
  logic    w_emit;
  count_t  w_frame_base;

  assign w_prev_h_plus1 = prev_h_q + hcount_t'(1);

  // A run can only continue from the immediately preceding column of the same
  // row; column 0 always starts a fresh run.
  assign w_line_break = (s1_hcount == '0) ||
                        (s1_hcount != w_prev_h_plus1) ||
                        (s1_vcount != prev_v_q);

  always_comb begin
    run_d    = run_q;
    prev_h_d = prev_h_q;
    prev_v_d = prev_v_q;
    // Idle cycles leave the run untouched, so gaps in valid_in do not break it.
    if (s1_valid) begin
      prev_h_d = s1_hcount;
      prev_v_d = s1_vcount;
      if (!s1_pass) begin
        run_d = '0;
      end else if (w_line_break) begin
        run_d = run_t'(1);
      end else if (run_q >= c_erode_len) begin
        run_d = c_erode_len;
      end else begin
        run_d = run_q + run_t'(1);
      end
    end
  end

  assign w_emit = s1_valid && (run_d >= c_erode_len);

  always_comb begin
    valid_out_d = w_emit;
    x_d         = x_q;
    y_d         = y_q;
    if (w_emit) begin
      // The run already spans ERODE_LEN columns, so this cannot go negative.
      x_d = s1_hcount - c_centre_offset;
      y_d = s1_vcount;
    end
    eof_d      = s1_valid && (s1_hcount == c_last_h) && (s1_vcount == c_last_v);
    tabulate_d = eof_q;
  end

  // The frame counter already includes the last pixel's increment when eof_q
  // is seen, so it is snapshotted then. A pixel emitted in that same cycle
  // belongs to the next frame and seeds the cleared counter.
  always_comb begin
    w_frame_base = eof_q ? '0 : frame_cnt_q;
    frame_cnt_d  = w_frame_base;
    if (valid_out_d && (w_frame_base != c_count_max)) begin
      frame_cnt_d = w_frame_base + count_t'(1);
    end
    pix_cnt_d = eof_q ? frame_cnt_q : pix_cnt_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      run_q       <= '0;
      prev_h_q    <= '0;
      prev_v_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      valid_out_q <= 1'b0;
      eof_q       <= 1'b0;
      tabulate_q  <= 1'b0;
      frame_cnt_q <= '0;
      pix_cnt_q   <= '0;
    end else begin
      run_q       <= run_d;
      prev_h_q    <= prev_h_d;
      prev_v_q    <= prev_v_d;
      x_q         <= x_d;
      y_q         <= y_d;
      valid_out_q <= valid_out_d;
      eof_q       <= eof_d;
      tabulate_q  <= tabulate_d;
      frame_cnt_q <= frame_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
    end
  end

  assign bus.x_out           = x_q;
  assign bus.y_out           = y_q;
  assign bus.valid_out       = valid_out_q;
  assign bus.tabulate_out    = tabulate_q;
  assign bus.pixel_count_out = pix_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mask_run_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mask_run_filter
//  Description : Self-checking bench for mask_run_filter on a reduced frame
//                size. A reference model keeps the recent pixel history and
//                predicts the mask/tabulate stream cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_run_filter;
  import vision_pkg::*;

  localparam int H = 40;
  localparam int V = 8;
  localparam int E = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mask_run_filter_if bus ();

  mask_run_filter #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .ERODE_LEN (E)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  typedef struct { int x; int y; bit p; } hist_t;
  typedef struct { int v; int h; int y; int pix; int lo; int up; int ev; int ex; int ey; } vec_t;

  hist_t hist[$];
  int    blo, bup, mcnt;
  bit    ev [8];
  int    ex [8];
  int    ey [8];
  bit    et [8];
  int    ec [8];
  int    mx, my, mpc;
  int    cyc, vectors, miscompares, tab_seen, vout_seen;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // True when the last E valid pixels form a passing run ending at (h, y).
  function automatic bit run_ok(int h, int y);
    int n;
    n = hist.size();
    if (n < E) return 1'b0;
    for (int k = 0; k < E; k++) begin
      if (!hist[n-1-k].p || hist[n-1-k].y != y || hist[n-1-k].x != h - k) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Drive one cycle, update the model, then check every output.
  task automatic step(input bit r, input bit v, input int h, input int y,
                      input int pix, input int lo, input int up);
    int    slot;
    bit    pass;
    hist_t e;
    rst                = r;
    bus.valid_in       = v;
    bus.hcount_in      = hcount_t'(h);
    bus.vcount_in      = vcount_t'(y);
    bus.pixel_in       = pixel_t'(pix);
    bus.lower_bound_in = pixel_t'(lo);
    bus.upper_bound_in = pixel_t'(up);
    if (r) begin
      hist.delete();
      blo = 0; bup = 0; mcnt = 0; mx = 0; my = 0; mpc = 0;
      for (int i = 0; i < 8; i++) begin ev[i] = 0; et[i] = 0; end
    end else if (v) begin
      if (h == 0 && y == 0) begin blo = lo; bup = up; end
      pass = (pix >= blo) && (pix <= bup);
      e.x = h; e.y = y; e.p = pass;
      hist.push_back(e);
      if (hist.size() > 16) void'(hist.pop_front());
      if (run_ok(h, y)) begin
        slot = (cyc + 2) % 8;
        ev[slot] = 1; ex[slot] = h - (E - 1) / 2; ey[slot] = y;
        mcnt++;
      end
      if (h == H - 1 && y == V - 1) begin
        slot = (cyc + 3) % 8;
        et[slot] = 1; ec[slot] = mcnt;
        mcnt = 0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    slot = cyc % 8;
    if (ev[slot]) begin mx = ex[slot]; my = ey[slot]; end
    if (et[slot]) mpc = ec[slot];
    chk("valid_out",       int'(bus.valid_out),       int'(ev[slot]));
    chk("tabulate_out",    int'(bus.tabulate_out),    int'(et[slot]));
    chk("x_out",           int'(bus.x_out),           mx);
    chk("y_out",           int'(bus.y_out),           my);
    chk("pixel_count_out", int'(bus.pixel_count_out), mpc);
    if (bus.tabulate_out) tab_seen++;
    if (bus.valid_out) vout_seen++;
    ev[slot] = 0;
    et[slot] = 0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, int'($urandom_range(H - 1)), int'($urandom_range(V - 1)),
         int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)));
  endtask

  // mode 0: all 150, mode 1: uniform random, mode 2: random 0 or 50
  task automatic frame(input int lo, input int up, input int mode, input int gap_pct,
                       input int skip_pct, input bit chg_mid, input bit drop_last);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        int pix, l, u;
        bit first, last;
        first = (x == 0) && (y == 0);
        last  = (x == H - 1) && (y == V - 1);
        if (drop_last && last) continue;
        if (skip_pct > 0 && !first && !last && int'($urandom_range(99)) < skip_pct) continue;
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) idle();
        case (mode)
          0:       pix = 150;
          1:       pix = int'($urandom_range(255));
          default: pix = ($urandom_range(1) == 0) ? 0 : 50;
        endcase
        l = lo; u = up;
        if (chg_mid && y >= V / 2) begin l = 0; u = 0; end
        step(1'b0, 1'b1, x, y, pix, l, u);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl [16];
    int   t0, v0;

    vectors = 0; miscompares = 0; cyc = 0; tab_seen = 0; vout_seen = 0;
    blo = 0; bup = 0; mcnt = 0; mx = 0; my = 0; mpc = 0;
    for (int i = 0; i < 8; i++) begin ev[i] = 0; et[i] = 0; ex[i] = 0; ey[i] = 0; ec[i] = 0; end
    rst = 1'b1;
    bus.valid_in = 1'b0; bus.hcount_in = '0; bus.vcount_in = '0;
    bus.pixel_in = '0; bus.lower_bound_in = '0; bus.upper_bound_in = '0;

    step(1'b1, 1'b0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 0, 0, 0);

    // Directed erosion vectors; expected outputs are those seen after the
    // edge that samples the row, i.e. for the row before it.
    //          v   h   y  pix  lo  up  ev  ex  ey
    tbl[0]  = '{1,  0,  0,   0, 100, 200, 0,  0, 0};
    tbl[1]  = '{1, 10,  5, 150,   0, 255, 0,  0, 0};
    tbl[2]  = '{1, 11,  5, 150,   0, 255, 0,  0, 0};
    tbl[3]  = '{1, 12,  5, 150,   0, 255, 0,  0, 0};
    tbl[4]  = '{1, 13,  5, 150,   0, 255, 1, 11, 5};
    tbl[5]  = '{1, 14,  5, 150,   0, 255, 1, 12, 5};
    tbl[6]  = '{0,  0,  0,   0,   0, 255, 1, 13, 5};
    tbl[7]  = '{0,  0,  0,   0,   0, 255, 0, 13, 5};
    tbl[8]  = '{1, 10,  6, 150,   0, 255, 0, 13, 5};
    tbl[9]  = '{1, 11,  6, 150,   0, 255, 0, 13, 5};
    tbl[10] = '{1, 12,  6,  99,   0, 255, 0, 13, 5};
    tbl[11] = '{1, 13,  6, 150,   0, 255, 0, 13, 5};
    tbl[12] = '{1, 14,  6, 150,   0, 255, 0, 13, 5};
    tbl[13] = '{1, 15,  6, 150,   0, 255, 0, 13, 5};
    tbl[14] = '{0,  0,  0,   0,   0, 255, 1, 14, 6};
    tbl[15] = '{0,  0,  0,   0,   0, 255, 0, 14, 6};
    for (int i = 0; i < 16; i++) begin
      step(1'b0, tbl[i].v != 0, tbl[i].h, tbl[i].y, tbl[i].pix, tbl[i].lo, tbl[i].up);
      chk("tbl_valid", int'(bus.valid_out), tbl[i].ev);
      chk("tbl_x",     int'(bus.x_out),     tbl[i].ex);
      chk("tbl_y",     int'(bus.y_out),     tbl[i].ey);
    end

    // Reset right after a passing run completes: its result must vanish.
    step(1'b0, 1'b1, 20, 3, 150, 0, 0);
    step(1'b0, 1'b1, 21, 3, 150, 0, 0);
    step(1'b0, 1'b1, 22, 3, 150, 0, 0);
    step(1'b1, 1'b0, 0, 0, 0, 0, 0);
    chk("rst_valid", int'(bus.valid_out), 0);
    chk("rst_x",     int'(bus.x_out), 0);
    chk("rst_y",     int'(bus.y_out), 0);
    chk("rst_tab",   int'(bus.tabulate_out), 0);
    step(1'b0, 1'b0, 0, 0, 0, 0, 0);
    chk("post_rst_valid", int'(bus.valid_out), 0);

    // Inverted window: nothing passes, one tabulate with a zero count.
    t0 = tab_seen; v0 = vout_seen;
    frame(200, 100, 1, 10, 0, 1'b0, 1'b0);
    repeat (4) idle();
    chk("inv_tabs",   tab_seen - t0, 1);
    chk("inv_valids", vout_seen - v0, 0);
    chk("inv_count",  int'(bus.pixel_count_out), 0);

    // Full frame, every pixel passes.
    t0 = tab_seen; v0 = vout_seen;
    frame(0, 255, 0, 0, 0, 1'b0, 1'b0);
    repeat (4) idle();
    chk("full_tabs",   tab_seen - t0, 1);
    chk("full_valids", vout_seen - v0, V * (H - 2));
    chk("full_count",  int'(bus.pixel_count_out), V * (H - 2));

    // Missing last pixel: no tabulate, count carries into the next frame.
    t0 = tab_seen;
    frame(0, 255, 0, 0, 0, 1'b0, 1'b1);
    repeat (4) idle();
    chk("miss_tabs", tab_seen - t0, 0);
    frame(0, 255, 0, 0, 0, 1'b0, 1'b0);
    repeat (4) idle();
    chk("miss_count", int'(bus.pixel_count_out), 2 * V * (H - 2) - 1);

    // Back-to-back frames with no gap across the frame boundary.
    frame(0, 255, 0, 0, 0, 1'b0, 1'b0);
    frame(60, 200, 1, 0, 0, 1'b0, 1'b0);
    repeat (4) idle();

    // Bounds changed mid-frame are ignored; the next frame uses [0,0].
    frame(60, 200, 1, 10, 0, 1'b1, 1'b0);
    frame(0, 0, 2, 10, 0, 1'b0, 1'b0);
    repeat (4) idle();

    // Randomised frames with gaps, skipped pixels and random windows.
    for (int f = 0; f < 4; f++) begin
      frame(int'($urandom_range(120)), int'($urandom_range(255, 100)), 1, 20, 5, 1'b0, 1'b0);
    end
    repeat (4) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
